// File: rtl/fpu_op_responder.sv
// fpu_op_responder: DUT-side endpoint of the FPU operand/result protocol.
// Accepts one operation per request, launches it on the FPU core, and watches
// its completion against a per-op latency budget. The result is held until it
// is acknowledged. A qNaN result and a sticky timeout are produced if the
// budget expires.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   opA, opB, fpuOp      operands and op (00 ADD, 01 SUB, 10 MUL, 11 DIV)
//   core_start           one-cycle launch pulse to the core
//   core_a/b/op          captured operands/op, stable from start to done
//   core_result/done     core result and completion strobe
//   fpuOut/out_valid     registered result, valid until out_ack
//   out_ack              result consumed
//   timeout              sticky budget-expiry flag
//   busy_cycles          cycles the last operation spent in BUSY
module fpu_op_responder #(
   parameter int unsigned ADD_LAT = 4,
   parameter int unsigned CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      opA,
   input  logic [31:0]      opB,
   input  logic [1:0]       fpuOp,
   output logic             core_start,
   output logic [31:0]      core_a,
   output logic [31:0]      core_b,
   output logic [1:0]       core_op,
   input  logic [31:0]      core_result,
   input  logic             core_done,
   output logic [31:0]      fpuOut,
   output logic             out_valid,
   input  logic             out_ack,
   output logic             timeout,
   output logic [CNT_W-1:0] busy_cycles
);

   localparam logic [31:0] QNAN = 32'h7FC0_0000;
   localparam logic [CNT_W-1:0] BUDGET_ADD = CNT_W'(ADD_LAT);
   localparam logic [CNT_W-1:0] BUDGET_MUL = CNT_W'(32 * ADD_LAT);

   typedef enum logic [1:0] {StIdle, StLaunch, StBusy, StHold} state_e;

   state_e           state_q, state_d;
   logic [31:0]      core_a_q, core_a_d;
   logic [31:0]      core_b_q, core_b_d;
   logic [1:0]       core_op_q, core_op_d;
   logic [31:0]      fpu_out_q, fpu_out_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] busy_cycles_q, busy_cycles_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [CNT_W-1:0] budget;
   logic             on_time;
   logic             expired;

   // Budget follows the captured op, so it stays fixed for the whole operation.
   assign budget  = core_op_q[1] ? BUDGET_MUL : BUDGET_ADD;
   // A done in the same cycle as the last budgeted count is still on time.
   assign on_time = core_done && (cnt_q <= budget);
   // The counter only ever reaches budget+1 here, since BUSY is left there.
   assign expired = !on_time && (cnt_q > budget);

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (req_valid) state_d = StLaunch;
         StLaunch: state_d = StBusy;
         StBusy:   if (on_time || expired) state_d = StHold;
         StHold:   if (out_ack) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      req_ready  = (state_q == StIdle);
      core_start = (state_q == StLaunch);
      out_valid  = (state_q == StHold);
   end

   // Datapath next state
   always_comb begin
      core_a_d      = core_a_q;
      core_b_d      = core_b_q;
      core_op_d     = core_op_q;
      fpu_out_d     = fpu_out_q;
      timeout_d     = timeout_q;
      busy_cycles_d = busy_cycles_q;
      cnt_d         = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               core_a_d  = opA;
               core_b_d  = opB;
               core_op_d = fpuOp;
               cnt_d     = '0;
            end
         end
         StLaunch: cnt_d = CNT_W'(1);
         StBusy: begin
            if (on_time) begin
               fpu_out_d     = core_result;
               busy_cycles_d = cnt_q;
            end else if (expired) begin
               fpu_out_d     = QNAN;
               timeout_d     = 1'b1;
               busy_cycles_d = budget + CNT_W'(1);
            end else if (cnt_q != {CNT_W{1'b1}}) begin
               // Saturate rather than wrap.
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         core_a_q      <= '0;
         core_b_q      <= '0;
         core_op_q     <= '0;
         fpu_out_q     <= '0;
         timeout_q     <= 1'b0;
         busy_cycles_q <= '0;
         cnt_q         <= '0;
      end else begin
         core_a_q      <= core_a_d;
         core_b_q      <= core_b_d;
         core_op_q     <= core_op_d;
         fpu_out_q     <= fpu_out_d;
         timeout_q     <= timeout_d;
         busy_cycles_q <= busy_cycles_d;
         cnt_q         <= cnt_d;
      end
   end

   assign core_a      = core_a_q;
   assign core_b      = core_b_q;
   assign core_op     = core_op_q;
   assign fpuOut      = fpu_out_q;
   assign timeout     = timeout_q;
   assign busy_cycles = busy_cycles_q;

endmodule

// File: tb/tb_fpu_op_responder.sv
module tb_fpu_op_responder;

   logic        clk;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] opA;
   logic [31:0] opB;
   logic [1:0]  fpuOp;
   logic        core_start;
   logic [31:0] core_a;
   logic [31:0] core_b;
   logic [1:0]  core_op;
   logic [31:0] core_result;
   logic        core_done;
   logic [31:0] fpuOut;
   logic        out_valid;
   logic        out_ack;
   logic        timeout;
   logic [7:0]  busy_cycles;

   int checks   = 0;
   int failures = 0;
   int n_start  = 0;
   int s0;

   fpu_op_responder #(.ADD_LAT(4), .CNT_W(8)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .opA         (opA),
      .opB         (opB),
      .fpuOp       (fpuOp),
      .core_start  (core_start),
      .core_a      (core_a),
      .core_b      (core_b),
      .core_op     (core_op),
      .core_result (core_result),
      .core_done   (core_done),
      .fpuOut      (fpuOut),
      .out_valid   (out_valid),
      .out_ack     (out_ack),
      .timeout     (timeout),
      .busy_cycles (busy_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launch-pulse counter, sampled mid-cycle.
   always @(negedge clk) if (core_start === 1'b1) n_start++;

   // All stimulus changes and checks happen 1 time unit after a falling edge.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // From IDLE: present a request for one cycle; returns in the LAUNCH cycle.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
      req_valid = 1'b1;
      opA       = a;
      opB       = b;
      fpuOp     = op;
      tick();
      req_valid = 1'b0;
   endtask

   // From LAUNCH: strobe core_done when the counter equals k; returns in HOLD.
   task automatic finish_at(input int k, input logic [31:0] res);
      repeat (k) tick();
      core_done   = 1'b1;
      core_result = res;
      tick();
      core_done   = 1'b0;
   endtask

   task automatic ack();
      out_ack = 1'b1;
      tick();
      out_ack = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (req_ready !== 1'b1) begin
         failures++; $display("FAIL reset_req_ready got=%b want=1", req_ready);
      end
      checks++;
      if (fpuOut !== 32'h0 || out_valid !== 1'b0 || timeout !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs got fpuOut=%h out_valid=%b timeout=%b want 0/0/0",
                  fpuOut, out_valid, timeout);
      end
      checks++;
      if (core_a !== 32'h0 || core_b !== 32'h0 || core_op !== 2'b00 || busy_cycles !== 8'd0
          || core_start !== 1'b0) begin
         failures++;
         $display("FAIL reset_core got a=%h b=%h op=%b bc=%0d start=%b want all 0",
                  core_a, core_b, core_op, busy_cycles, core_start);
      end
   endtask

   task automatic test_add();
      s0 = n_start;
      issue(32'h3F80_0000, 32'h4000_0000, 2'b00);
      checks++;
      if (core_start !== 1'b1 || req_ready !== 1'b0) begin
         failures++;
         $display("FAIL add_launch got start=%b ready=%b want 1/0", core_start, req_ready);
      end
      checks++;
      if (core_a !== 32'h3F80_0000 || core_b !== 32'h4000_0000 || core_op !== 2'b00) begin
         failures++;
         $display("FAIL add_capture got a=%h b=%h op=%b want 3f800000/40000000/00",
                  core_a, core_b, core_op);
      end
      finish_at(3, 32'h4040_0000);
      checks++;
      if (out_valid !== 1'b1 || fpuOut !== 32'h4040_0000) begin
         failures++;
         $display("FAIL add_result got valid=%b fpuOut=%h want 1/40400000", out_valid, fpuOut);
      end
      checks++;
      if (busy_cycles !== 8'd3 || timeout !== 1'b0 || n_start - s0 != 1) begin
         failures++;
         $display("FAIL add_stats got bc=%0d timeout=%b starts=%0d want 3/0/1",
                  busy_cycles, timeout, n_start - s0);
      end
      ack();
      checks++;
      if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL add_ack got valid=%b ready=%b want 0/1", out_valid, req_ready);
      end
   endtask

   // Done exactly at the add budget (counter == 4) is on time.
   task automatic test_add_boundary();
      issue(32'h4000_0000, 32'h4000_0000, 2'b01);
      finish_at(4, 32'h0000_0000);
      checks++;
      if (fpuOut !== 32'h0 || busy_cycles !== 8'd4 || timeout !== 1'b0 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL sub_at_budget got fpuOut=%h bc=%0d timeout=%b valid=%b want 0/4/0/1",
                  fpuOut, busy_cycles, timeout, out_valid);
      end
      ack();
   endtask

   task automatic test_mul();
      issue(32'h4000_0000, 32'h4040_0000, 2'b10);
      finish_at(128, 32'h40C0_0000);
      checks++;
      if (fpuOut !== 32'h40C0_0000 || busy_cycles !== 8'd128 || timeout !== 1'b0) begin
         failures++;
         $display("FAIL mul_at_budget got fpuOut=%h bc=%0d timeout=%b want 40c00000/128/0",
                  fpuOut, busy_cycles, timeout);
      end
      ack();
   endtask

   task automatic test_protocol_abuse();
      s0 = n_start;
      issue(32'h1111_1111, 32'h2222_2222, 2'b00);
      tick();
      req_valid = 1'b1;
      opA       = 32'hAAAA_AAAA;
      opB       = 32'hBBBB_BBBB;
      fpuOp     = 2'b11;
      out_ack   = 1'b1;
      tick();
      tick();
      req_valid = 1'b0;
      out_ack   = 1'b0;
      checks++;
      if (core_a !== 32'h1111_1111 || core_b !== 32'h2222_2222 || core_op !== 2'b00) begin
         failures++;
         $display("FAIL abuse_operands got a=%h b=%h op=%b want 11111111/22222222/00",
                  core_a, core_b, core_op);
      end
      checks++;
      if (n_start - s0 != 1 || out_valid !== 1'b0 || req_ready !== 1'b0) begin
         failures++;
         $display("FAIL abuse_ctrl got starts=%0d valid=%b ready=%b want 1/0/0",
                  n_start - s0, out_valid, req_ready);
      end
      // Counter is 3 here.
      core_done   = 1'b1;
      core_result = 32'h3333_3333;
      tick();
      core_done   = 1'b0;
      checks++;
      if (fpuOut !== 32'h3333_3333 || busy_cycles !== 8'd3) begin
         failures++;
         $display("FAIL abuse_result got fpuOut=%h bc=%0d want 33333333/3", fpuOut, busy_cycles);
      end
      ack();
   endtask

   task automatic test_back_to_back();
      issue(32'h3F80_0000, 32'h3F80_0000, 2'b00);
      finish_at(2, 32'h4000_0000);
      s0        = n_start;
      req_valid = 1'b1;
      opA       = 32'h4080_0000;
      opB       = 32'h4100_0000;
      fpuOp     = 2'b10;
      tick();
      checks++;
      if (out_valid !== 1'b1 || fpuOut !== 32'h4000_0000 || n_start != s0 || req_ready !== 1'b0)
      begin
         failures++;
         $display("FAIL b2b_hold got valid=%b fpuOut=%h starts=%0d ready=%b want 1/40000000/0/0",
                  out_valid, fpuOut, n_start - s0, req_ready);
      end
      ack();
      checks++;
      if (req_ready !== 1'b1 || core_start !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_idle got ready=%b start=%b valid=%b want 1/0/0",
                  req_ready, core_start, out_valid);
      end
      tick();
      req_valid = 1'b0;
      checks++;
      if (core_start !== 1'b1 || core_a !== 32'h4080_0000 || core_op !== 2'b10) begin
         failures++;
         $display("FAIL b2b_launch got start=%b a=%h op=%b want 1/40800000/10",
                  core_start, core_a, core_op);
      end
      finish_at(5, 32'h4200_0000);
      checks++;
      if (fpuOut !== 32'h4200_0000 || busy_cycles !== 8'd5 || timeout !== 1'b0) begin
         failures++;
         $display("FAIL b2b_result got fpuOut=%h bc=%0d timeout=%b want 42000000/5/0",
                  fpuOut, busy_cycles, timeout);
      end
      ack();
   endtask

   task automatic test_timeout();
      issue(32'h4000_0000, 32'h3F80_0000, 2'b01);
      repeat (5) tick();
      checks++;
      if (out_valid !== 1'b0 || timeout !== 1'b0) begin
         failures++;
         $display("FAIL timeout_early got valid=%b timeout=%b want 0/0", out_valid, timeout);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || fpuOut !== 32'h7FC0_0000 || timeout !== 1'b1
          || busy_cycles !== 8'd5) begin
         failures++;
         $display("FAIL timeout_fire got valid=%b fpuOut=%h timeout=%b bc=%0d want 1/7fc00000/1/5",
                  out_valid, fpuOut, timeout, busy_cycles);
      end
      core_done   = 1'b1;
      core_result = 32'h1234_5678;
      tick();
      core_done   = 1'b0;
      checks++;
      if (fpuOut !== 32'h7FC0_0000 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL late_done got fpuOut=%h valid=%b want 7fc00000/1", fpuOut, out_valid);
      end
      ack();
      checks++;
      if (timeout !== 1'b1) begin
         failures++; $display("FAIL timeout_sticky got=%b want=1", timeout);
      end
   endtask

   task automatic test_reset_mid_busy();
      issue(32'h5555_5555, 32'h6666_6666, 2'b11);
      tick();
      tick();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      s0          = n_start;
      core_done   = 1'b1;
      core_result = 32'hDEAD_BEEF;
      tick();
      core_done   = 1'b0;
      tick();
      checks++;
      if (req_ready !== 1'b1 || out_valid !== 1'b0 || n_start != s0) begin
         failures++;
         $display("FAIL rst_busy_state got ready=%b valid=%b starts=%0d want 1/0/0",
                  req_ready, out_valid, n_start - s0);
      end
      checks++;
      if (timeout !== 1'b0 || fpuOut !== 32'h0 || core_a !== 32'h0 || busy_cycles !== 8'd0) begin
         failures++;
         $display("FAIL rst_busy_regs got timeout=%b fpuOut=%h a=%h bc=%0d want 0/0/0/0",
                  timeout, fpuOut, core_a, busy_cycles);
      end
   endtask

   initial begin
      reset_n     = 1'b0;
      req_valid   = 1'b0;
      opA         = '0;
      opB         = '0;
      fpuOp       = '0;
      core_result = '0;
      core_done   = 1'b0;
      out_ack     = 1'b0;
      tick();
      tick();
      test_reset();
      reset_n = 1'b1;
      tick();
      test_add();
      test_add_boundary();
      test_mul();
      test_protocol_abuse();
      test_back_to_back();
      test_timeout();
      test_reset_mid_busy();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Guard against a stuck run.
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fpu_op_responder.md
Name: fpu_op_responder

Overview:
- DUT-side endpoint of the FPU operand/result protocol: accepts one operation (opA, opB, fpuOp) per request, launches it on the FPU core and tracks its completion against the per-op latency budget.
- Registers and holds fpuOut until the stimulus side acknowledges it.
- Enforces the latency contract the bench relies on: add/sub within ADD_LAT cycles, mul/div within 32*ADD_LAT cycles; flags a timeout otherwise.
- Sits between the testbench driver and the fpu core.

Parameters:
- ADD_LAT, 4, cycle budget for add/sub; mul/div budget = 32*ADD_LAT.
- CNT_W, 8, latency counter width; must hold 32*ADD_LAT (ADD_LAT=4 gives 128).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  operation request.
- req_ready  out  1  responder idle, request accepted on req_valid&&req_ready.
- opA  in  32  IEEE-754 single operand A.
- opB  in  32  IEEE-754 single operand B.
- fpuOp  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV; bit1 = mul/div.
- core_start  out  1  one-cycle pulse launching the core.
- core_a, core_b  out  32  captured operands, stable from start until done.
- core_op  out  2  captured op.
- core_result  in  32  core result, valid with core_done.
- core_done  in  1  core completion strobe; ignored outside BUSY.
- fpuOut  out  32  registered result.
- out_valid  out  1  fpuOut valid, held until out_ack.
- out_ack  in  1  result consumed.
- timeout  out  1  sticky; set when the budget expires.
- busy_cycles  out  CNT_W  cycles the last operation spent in BUSY.

Behaviour:
- Reset (async, any state): state=IDLE, req_ready=1, core_start=0, core_a/core_b=0, core_op=0, fpuOut=0, out_valid=0, timeout=0, busy_cycles=0. An in-flight op is abandoned; a later core_done is ignored.
- FSM states: IDLE, LAUNCH, BUSY, HOLD.
- IDLE: req_ready=1. On req_valid, capture opA/opB/fpuOp into core_a/core_b/core_op, clear the counter, go to LAUNCH.
- LAUNCH: core_start=1 for exactly one cycle, counter=1, then go to BUSY. req_ready=0 in every state except IDLE.
- BUSY: counter increments each cycle.
  - core_done=1 with counter <= budget: fpuOut<=core_result, busy_cycles<=counter, out_valid<=1, go to HOLD.
  - counter reaches budget+1 with no core_done: fpuOut<=32'h7FC00000 (qNaN), timeout<=1, busy_cycles<=budget+1, out_valid<=1, go to HOLD.
  - core_done in the same cycle as budget expiry: counts as on-time.
- Budget = ADD_LAT when core_op[1]=0, else 32*ADD_LAT. Compute it in CNT_W bits. Counter saturates; it never wraps.
- HOLD: out_valid=1 and fpuOut stable until out_ack. On out_ack, out_valid<=0 and go to IDLE. The next request is accepted one cycle after the ack (no same-cycle ack+accept).
- Latency, normal case: a request accepted in cycle N pulses core_start in N+1. core_done in cycle M gives out_valid=1 from M+1.
- req_valid outside IDLE is ignored and is not queued.
- core_done outside BUSY is ignored.
- out_ack outside HOLD is ignored.
- timeout is cleared only by reset.

Test Plan:
- Reset mid-BUSY: assert reset_n=0 for 2 cycles, then pulse core_done → state IDLE, out_valid stays 0, timeout=0, fpuOut=0.
- ADD: opA=3F800000, opB=40000000, fpuOp=00; core_done after 3 cycles with core_result=40400000 → single core_start, fpuOut=40400000, busy_cycles=3, timeout=0.
- MUL within budget: opA=40000000, opB=40400000, fpuOp=10; core_done at cycle 128 with result 40C00000 → on-time, busy_cycles=128, timeout=0.
- SUB timeout: fpuOp=01, no core_done → fpuOut=7FC00000, timeout=1 set at counter=5, busy_cycles=5; a late core_done in HOLD is ignored.
- Back-to-back: hold req_valid=1 continuously, out_ack pulse in cycle K → req_ready=1 at K+1, second request accepted at K+1, core_start at K+2.
- Protocol abuse: req_valid with new operands during BUSY, out_ack during BUSY → core_a/core_b/core_op unchanged, no extra core_start, out_valid unaffected.
